ubs_tx_arb: RTL and testbench

Packet-granular round-robin arbiter that shares the single UBS transmit path between up to four packet sources, such as the handshake generator, the data engine and the control responder. The transmit path is the CRC16 transmit stage and the link layer behind it. A grant is held from the SOP beat to the EOP beat, so packets never interleave. A programmable inter-packet gap is inserted after every EOP. The block sits between the protocol-layer packet sources and the CRC16 transmit stage, using the same sop/eop/valid/ready byte-stream convention.

---
 rtl/ubs_tx_arb_pkg.sv | 23 ++
 rtl/ubs_tx_arb_if.sv | 30 +++
 rtl/ubs_rr_pick.sv | 38 +++
 rtl/ubs_tx_arb.sv | 139 +++++++++++++
 tb/tb_ubs_tx_arb.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ubs_tx_arb_pkg.sv
// Shared types and constants for the UBS transmit-path arbiter and its
// rotating-priority picker.
package ubs_tx_arb_pkg;

  localparam int unsigned N_REQ_MAX = 4;
  localparam int unsigned ID_W      = 2;
  localparam int unsigned GAP_CNT_W = 4;
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // One byte-stream beat as seen on the muxed transmit path.
  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [BYTE_W-1:0] data;
  } ubs_beat_t;

endpackage

// File: rtl/ubs_tx_arb_if.sv
// Packet-source and transmit-side byte-stream signals of the UBS tx arbiter.
// master: the arbiter; slave: the sources plus the downstream CRC16 stage.
interface ubs_tx_arb_if #(
  parameter int unsigned N_REQ = 2
);
  import ubs_tx_arb_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_sop;
  logic [N_REQ-1:0]        req_eop;
  logic [BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;

  logic                    tx_ready;
  logic                    tx_valid;
  logic                    tx_sop;
  logic                    tx_eop;
  logic [BYTE_W-1:0]       tx_data;

  modport master (
    input  req_valid, req_sop, req_eop, req_data, tx_ready,
    output req_ready, tx_valid, tx_sop, tx_eop, tx_data
  );

  modport slave (
    output req_valid, req_sop, req_eop, req_data, tx_ready,
    input  req_ready, tx_valid, tx_sop, tx_eop, tx_data
  );

endinterface

// File: rtl/ubs_rr_pick.sv
// Combinational rotating-priority picker: searches from last+1 (mod N_REQ),
// wrapping, and returns the first eligible index.
module ubs_rr_pick
  import ubs_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  winner_c,
  output logic             found_c
);

  localparam int unsigned IDX_W = ID_W + 1;

  logic [N_REQ_MAX-1:0] elig_pad;
  logic [IDX_W-1:0]     idx;

  assign elig_pad = N_REQ_MAX'(eligible);

  // Walk offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    winner_c = '0;
    found_c  = 1'b0;
    idx      = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      idx = IDX_W'(last) + IDX_W'(k);
      if (idx >= IDX_W'(N_REQ)) begin
        idx = idx - IDX_W'(N_REQ);
      end
      if (elig_pad[idx[ID_W-1:0]]) begin
        winner_c = idx[ID_W-1:0];
        found_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ubs_tx_arb.sv
// Packet-granular round-robin arbiter sharing the UBS transmit path between up
// to four sources; grants are held SOP..EOP and followed by an inter-packet gap.
module ubs_tx_arb
  import ubs_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IPG   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  ubs_tx_arb_if.master    bus,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic            pkt_err
);

  localparam int unsigned           DATA_PAD_W = BYTE_W * N_REQ_MAX;
  localparam logic [ID_W-1:0]       GRANT_RST  = ID_W'(N_REQ - 1);
  localparam logic [GAP_CNT_W-1:0]  GAP_LOAD   = (IPG == 0) ? '0 : GAP_CNT_W'(IPG - 1);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;
  logic                 in_pkt_q, in_pkt_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  logic [N_REQ-1:0]                  eligible;
  logic [ID_W-1:0]                   pick_c;
  logic                              found_c;
  logic [N_REQ_MAX-1:0]              valid_pad;
  logic [N_REQ_MAX-1:0]              sop_pad;
  logic [N_REQ_MAX-1:0]              eop_pad;
  logic [N_REQ_MAX-1:0][BYTE_W-1:0]  data_pad;
  logic [N_REQ_MAX-1:0]              ready_pad;
  ubs_beat_t                         sel_beat;
  logic                              sel_valid;
  logic                              xfer;

  assign eligible  = bus.req_valid & bus.req_sop;
  assign valid_pad = N_REQ_MAX'(bus.req_valid);
  assign sop_pad   = N_REQ_MAX'(bus.req_sop);
  assign eop_pad   = N_REQ_MAX'(bus.req_eop);
  assign data_pad  = DATA_PAD_W'(bus.req_data);

  assign sel_valid = valid_pad[grant_q];
  assign sel_beat  = {sop_pad[grant_q], eop_pad[grant_q], data_pad[grant_q]};
  assign xfer      = (state_q == GRANT) && sel_valid && bus.tx_ready;

  ubs_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .eligible (eligible),
    .last     (grant_q),
    .winner_c (pick_c),
    .found_c  (found_c)
  );

  // Zero-latency mux of the granted source; everything is quiet outside GRANT.
  always_comb begin
    ready_pad    = '0;
    bus.tx_valid = 1'b0;
    bus.tx_sop   = 1'b0;
    bus.tx_eop   = 1'b0;
    bus.tx_data  = '0;
    if (state_q == GRANT) begin
      ready_pad[grant_q] = bus.tx_ready;
      bus.tx_valid       = sel_valid;
      bus.tx_sop         = sel_beat.sop;
      bus.tx_eop         = sel_beat.eop;
      bus.tx_data        = sel_beat.data;
    end
    bus.req_ready = ready_pad[N_REQ-1:0];
  end

  // Next-state logic; in_pkt marks that the first beat of the grant has moved.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gap_d    = gap_q;
    in_pkt_d = in_pkt_q;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          grant_d = pick_c;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          err_d    = sel_beat.sop & in_pkt_q;
          in_pkt_d = 1'b1;
          if (sel_beat.eop) begin
            in_pkt_d = 1'b0;
            if (IPG == 0) begin
              state_d = IDLE;
            end else begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= GRANT_RST;
      gap_q    <= '0;
      in_pkt_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gap_q    <= gap_d;
      in_pkt_q <= in_pkt_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign pkt_err  = err_q;

endmodule

// File: tb/tb_ubs_tx_arb.sv
// Directed bench for ubs_tx_arb: a 2-source IPG=2 instance driven from a
// per-cycle vector table, plus a 4-source IPG=0 instance for single-beat rotation.
module tb_ubs_tx_arb;
  import ubs_tx_arb_pkg::*;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ubs_tx_arb_if #(.N_REQ(2)) bus_a ();
  ubs_tx_arb_if #(.N_REQ(4)) bus_b ();

  logic [1:0] gid_a, gid_b;
  logic       busy_a, busy_b, err_a, err_b;

  ubs_tx_arb #(.N_REQ(2), .IPG(2)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_a),
    .grant_id (gid_a),
    .busy     (busy_a),
    .pkt_err  (err_a)
  );

  ubs_tx_arb #(.N_REQ(4), .IPG(0)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_b),
    .grant_id (gid_b),
    .busy     (busy_b),
    .pkt_err  (err_b)
  );

  typedef struct {
    logic [1:0]  v, s, e;
    logic [15:0] d;
    logic        r;
    logic        ev, es, ee;
    logic [7:0]  ed;
    logic [1:0]  erdy, egid;
    logic        eb, eerr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer = 0;

  function automatic vec_t mk(input int v, input int s, input int e, input int d, input int r,
                              input int ev, input int es, input int ee, input int ed,
                              input int erdy, input int egid, input int eb, input int eerr);
    vec_t t;
    t.v = 2'(v);  t.s = 2'(s);  t.e = 2'(e);  t.d = 16'(d);  t.r = 1'(r);
    t.ev = 1'(ev); t.es = 1'(es); t.ee = 1'(ee); t.ed = 8'(ed);
    t.erdy = 2'(erdy); t.egid = 2'(egid); t.eb = 1'(eb); t.eerr = 1'(eerr);
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic [1:0] v, input logic [1:0] s, input logic [1:0] e,
                         input logic [15:0] d, input logic r);
    bus_a.req_valid = v;
    bus_a.req_sop   = s;
    bus_a.req_eop   = e;
    bus_a.req_data  = d;
    bus_a.tx_ready  = r;
  endtask

  function automatic logic [16:0] pack_a();
    return {bus_a.tx_valid, bus_a.tx_sop, bus_a.tx_eop, bus_a.tx_data,
            bus_a.req_ready, gid_a, busy_a, err_a};
  endfunction

  function automatic logic [18:0] pack_b();
    return {bus_b.tx_valid, bus_b.tx_sop, bus_b.tx_eop, bus_b.tx_data,
            bus_b.req_ready, gid_b, busy_b, err_b};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];

    // fields: v s e data rdy | exp: valid sop eop data ready gid busy err
    vecs.push_back(mk(0,0,0,'h0000,1, 0,0,0,'h00,0,1,0,0));
    // contention, 2-byte packets from both sources: grants 0,1,0,1
    vecs.push_back(mk(3,3,0,'h2010,1, 0,0,0,'h00,0,1,0,0));
    vecs.push_back(mk(3,3,0,'h2010,1, 1,1,0,'h10,1,0,1,0));
    vecs.push_back(mk(3,2,1,'h2011,1, 1,0,1,'h11,1,0,1,0));
    vecs.push_back(mk(3,3,0,'h2012,1, 0,0,0,'h00,0,0,1,0));
    vecs.push_back(mk(3,3,0,'h2012,1, 0,0,0,'h00,0,0,1,0));
    vecs.push_back(mk(3,3,0,'h2012,1, 0,0,0,'h00,0,0,0,0));
    vecs.push_back(mk(3,3,0,'h2012,1, 1,1,0,'h20,2,1,1,0));
    vecs.push_back(mk(3,1,2,'h2112,1, 1,0,1,'h21,2,1,1,0));
    vecs.push_back(mk(3,3,0,'h2212,1, 0,0,0,'h00,0,1,1,0));
    vecs.push_back(mk(3,3,0,'h2212,1, 0,0,0,'h00,0,1,1,0));
    vecs.push_back(mk(3,3,0,'h2212,1, 0,0,0,'h00,0,1,0,0));
    vecs.push_back(mk(3,3,0,'h2212,1, 1,1,0,'h12,1,0,1,0));
    vecs.push_back(mk(3,2,1,'h2213,1, 1,0,1,'h13,1,0,1,0));
    vecs.push_back(mk(2,2,0,'h2200,1, 0,0,0,'h00,0,0,1,0));
    vecs.push_back(mk(2,2,0,'h2200,1, 0,0,0,'h00,0,0,1,0));
    vecs.push_back(mk(2,2,0,'h2200,1, 0,0,0,'h00,0,0,0,0));
    vecs.push_back(mk(2,2,0,'h2200,1, 1,1,0,'h22,2,1,1,0));
    vecs.push_back(mk(2,0,2,'h2300,1, 1,0,1,'h23,2,1,1,0));
    vecs.push_back(mk(0,0,0,'h0000,1, 0,0,0,'h00,0,1,1,0));
    vecs.push_back(mk(0,0,0,'h0000,1, 0,0,0,'h00,0,1,1,0));
    vecs.push_back(mk(0,0,0,'h0000,1, 0,0,0,'h00,0,1,0,0));
    // single requester: A1 B2 C3, two gap cycles after EOP
    vecs.push_back(mk(1,1,0,'h00A1,1, 0,0,0,'h00,0,1,0,0));
    vecs.push_back(mk(1,1,0,'h00A1,1, 1,1,0,'hA1,1,0,1,0));
    vecs.push_back(mk(1,0,0,'h00B2,1, 1,0,0,'hB2,1,0,1,0));
    vecs.push_back(mk(1,0,1,'h00C3,1, 1,0,1,'hC3,1,0,1,0));
    vecs.push_back(mk(0,0,0,'h0000,1, 0,0,0,'h00,0,0,1,0));
    vecs.push_back(mk(0,0,0,'h0000,1, 0,0,0,'h00,0,0,1,0));
    vecs.push_back(mk(0,0,0,'h0000,1, 0,0,0,'h00,0,0,0,0));
    // back-pressure on req1: tx_ready 1,0,0,1, then a valid drop mid-packet
    vecs.push_back(mk(2,2,0,'h3000,1, 0,0,0,'h00,0,0,0,0));
    vecs.push_back(mk(2,2,0,'h3000,1, 1,1,0,'h30,2,1,1,0));
    vecs.push_back(mk(2,0,0,'h3100,0, 1,0,0,'h31,0,1,1,0));
    vecs.push_back(mk(2,0,0,'h3100,0, 1,0,0,'h31,0,1,1,0));
    vecs.push_back(mk(2,0,0,'h3100,1, 1,0,0,'h31,2,1,1,0));
    vecs.push_back(mk(0,0,0,'h0000,1, 0,0,0,'h00,2,1,1,0));
    vecs.push_back(mk(2,0,2,'h3200,1, 1,0,1,'h32,2,1,1,0));
    vecs.push_back(mk(0,0,0,'h0000,1, 0,0,0,'h00,0,1,1,0));
    vecs.push_back(mk(0,0,0,'h0000,1, 0,0,0,'h00,0,1,1,0));
    vecs.push_back(mk(0,0,0,'h0000,1, 0,0,0,'h00,0,1,0,0));
    // framing error: stray sop on beat 2, forwarded, pkt_err one cycle later
    vecs.push_back(mk(1,1,0,'h0040,1, 0,0,0,'h00,0,1,0,0));
    vecs.push_back(mk(1,1,0,'h0040,1, 1,1,0,'h40,1,0,1,0));
    vecs.push_back(mk(1,1,0,'h0041,1, 1,1,0,'h41,1,0,1,0));
    vecs.push_back(mk(1,0,1,'h0042,1, 1,0,1,'h42,1,0,1,1));
    vecs.push_back(mk(0,0,0,'h0000,1, 0,0,0,'h00,0,0,1,0));
    vecs.push_back(mk(0,0,0,'h0000,1, 0,0,0,'h00,0,0,1,0));
    vecs.push_back(mk(0,0,0,'h0000,1, 0,0,0,'h00,0,0,0,0));

    rst_n = 1'b1;
    drive_a(2'b00, 2'b00, 2'b00, 16'h0000, 1'b1);
    bus_b.req_valid = '0;
    bus_b.req_sop   = '0;
    bus_b.req_eop   = '0;
    bus_b.req_data  = '0;
    bus_b.tx_ready  = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_a", 32'(pack_a()), 32'({3'b000, 8'h00, 2'b00, 2'd1, 1'b0, 1'b0}));
    check("reset_b", 32'(pack_b()), 32'({3'b000, 8'h00, 4'b0000, 2'd3, 1'b0, 1'b0}));
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive_a(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].d, vecs[i].r);
      #1;
      check($sformatf("row%0d", i), 32'(pack_a()),
            32'({vecs[i].ev, vecs[i].es, vecs[i].ee, vecs[i].ed,
                 vecs[i].erdy, vecs[i].egid, vecs[i].eb, vecs[i].eerr}));
      if (bus_a.tx_valid && bus_a.tx_ready) n_xfer++;
    end
    check("byte_count", 32'(n_xfer), 32'd17);

    // reset asserted while byte 2 of a req1 packet is on the bus
    @(negedge clk) drive_a(2'b10, 2'b10, 2'b00, 16'h5000, 1'b1);
    @(negedge clk);
    #1 check("rst_pre_byte1", 32'({bus_a.tx_valid, bus_a.tx_data, gid_a}), 32'({1'b1, 8'h50, 2'd1}));
    @(negedge clk) drive_a(2'b10, 2'b00, 2'b00, 16'h5100, 1'b1);
    #1 check("rst_pre_byte2", 32'({bus_a.tx_valid, bus_a.tx_data}), 32'({1'b1, 8'h51}));
    #2 rst_n = 1'b0;
    #1 check("rst_async", 32'(pack_a()), 32'({3'b000, 8'h00, 2'b00, 2'd1, 1'b0, 1'b0}));
    drive_a(2'b00, 2'b00, 2'b00, 16'h0000, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk) drive_a(2'b11, 2'b11, 2'b00, 16'h7060, 1'b1);
    #1 check("post_rst_idle", 32'({bus_a.tx_valid, gid_a, busy_a}), 32'({1'b0, 2'd1, 1'b0}));
    @(negedge clk);
    #1 check("post_rst_req0", 32'({bus_a.tx_valid, bus_a.tx_data, bus_a.req_ready, gid_a}),
             32'({1'b1, 8'h60, 2'b01, 2'd0}));
    drive_a(2'b00, 2'b00, 2'b00, 16'h0000, 1'b1);

    // 4 sources, IPG=0, back-to-back single-beat packets: grant every other cycle
    @(negedge clk);
    bus_b.req_valid = 4'hF;
    bus_b.req_sop   = 4'hF;
    bus_b.req_eop   = 4'hF;
    bus_b.req_data  = 32'hB3B2B1B0;
    #1 check("b_idle", 32'({bus_b.tx_valid, busy_b, gid_b}), 32'({1'b0, 1'b0, 2'd3}));
    for (int p = 0; p < 6; p++) begin
      int g;
      g = p % 4;
      @(negedge clk);
      #1 check($sformatf("b_grant%0d", p), 32'(pack_b()),
               32'({3'b111, 8'(8'hB0 + g), 4'(1 << g), 2'(g), 1'b1, 1'b0}));
      @(negedge clk);
      #1 check($sformatf("b_gapless%0d", p), 32'({bus_b.tx_valid, bus_b.req_ready, gid_b, busy_b}),
               32'({1'b0, 4'b0000, 2'(g), 1'b0}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
